// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-channel registered multiplexer with valid/ready handshake.
//   Channel choice is either a fixed external select (MODE 0) or
//   round-robin arbitration across the valid channels (MODE 1).
//   Latency is 1 cycle. Full throughput: drain and fill can happen on the same edge.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   in_data/in_valid/in_ready  NUM_CH producer channels (data packed i*WIDTH +: WIDTH)
//   sel                        channel select, used only in MODE 0
//   out_data/out_ch/out_valid  registered word, its source channel, and its valid flag
//   out_ready                  consumer accept
module mux_arb_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic             load;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic [WIDTH-1:0] gnt_dat;
  logic [SEL_W-1:0] rr_ptr;

  // The output register can take a new word when it is empty or being drained.
  assign load = !out_valid || out_ready;

  // Grant selection. Depends only on in_valid/sel/rr_ptr, never on in_data.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    if (MODE == 0) begin
      // An out-of-range sel matches no channel, so it yields no grant.
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(i);
        end
      end
    end else begin
      // Scan from the farthest offset down to rr_ptr+1 so the nearest valid
      // channel after the last winner is written last and wins.
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = (int'(rr_ptr) + k) % NUM_CH;
        if (in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(idx);
        end
      end
    end
  end

  // Accept strobe back to the winning producer; held low during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = !reset && load && gnt_vld && (gnt == SEL_W'(i));
    end
  end

  always_comb begin
    gnt_dat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt == SEL_W'(i)) gnt_dat = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (load) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= gnt_dat;
        out_ch    <= gnt;
        rr_ptr    <= gnt;
      end else begin
        // Nothing to load: the slot empties, but the last data/channel stay visible.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: one MODE 0 and one MODE 1 instance share all stimulus.
// A queue-free reference model predicts every output each cycle, while
// directed scenarios add hand-computed literal expectations.
module tb_mux_arb_reg;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  ir [2];
  logic [7:0]  od [2];
  logic [1:0]  oc [2];
  logic        ov [2];

  int checks = 0;
  int errors = 0;

  mux_arb_reg #(.WIDTH(8), .NUM_CH(4), .SEL_W(2), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[0]), .sel(sel), .out_data(od[0]), .out_ch(oc[0]),
    .out_valid(ov[0]), .out_ready(out_ready)
  );

  mux_arb_reg #(.WIDTH(8), .NUM_CH(4), .SEL_W(2), .MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[1]), .sel(sel), .out_data(od[1]), .out_ch(oc[1]),
    .out_valid(ov[1]), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the winning channel, or -1 when nobody may transfer.
  function automatic int exp_grant(int m, logic [3:0] v, logic [1:0] s, int rr);
    int c;
    if (m == 0) return v[s] ? int'(s) : -1;
    for (int step = 1; step <= 4; step++) begin
      c = (rr + step) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  logic       mv  [2];
  logic [7:0] md  [2];
  logic [1:0] mc  [2];
  int         mrr [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        mv[m] <= 1'b0; md[m] <= 8'h00; mc[m] <= 2'd0; mrr[m] <= 3;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int g;
        g = exp_grant(m, in_valid, sel, mrr[m]);
        if (!mv[m] || out_ready) begin
          if (g >= 0) begin
            mv[m] <= 1'b1; md[m] <= in_data[g*8 +: 8]; mc[m] <= 2'(g); mrr[m] <= g;
          end else begin
            mv[m] <= 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int g;
      logic [3:0] eir;
      g = exp_grant(m, in_valid, sel, mrr[m]);
      eir = (!reset && (!mv[m] || out_ready) && g >= 0) ? 4'(1 << g) : 4'b0000;
      chk($sformatf("model_in_ready_m%0d", m), 32'(ir[m]), 32'(eir));
      chk($sformatf("model_out_valid_m%0d", m), 32'(ov[m]), 32'(mv[m]));
      chk($sformatf("model_out_data_m%0d", m), 32'(od[m]), 32'(md[m]));
      chk($sformatf("model_out_ch_m%0d", m), 32'(oc[m]), 32'(mc[m]));
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    after_edge();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = 32'h13_12_11_10;
    in_valid  = 4'b0000;
    sel       = 2'd0;
    out_ready = 1'b0;
    after_edge();
    after_edge();
    reset = 1'b0;

    // T2: fixed select of channel 2.
    in_data   = 32'h33_A5_11_10;
    in_valid  = 4'b1111;
    sel       = 2'd2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_in_ready", 32'(ir[0]), 32'h4);
    after_edge();
    chk("t2_out_data", 32'(od[0]), 32'hA5);
    chk("t2_out_ch", 32'(oc[0]), 32'd2);
    chk("t2_out_valid", 32'(ov[0]), 32'd1);

    // T3: selected channel not valid -> no accept, register empties.
    sel      = 2'd1;
    in_valid = 4'b1101;
    @(negedge clk);
    chk("t3_in_ready", 32'(ir[0]), 32'h0);
    after_edge();
    chk("t3_out_valid", 32'(ov[0]), 32'd0);
    chk("t3_out_data_hold", 32'(od[0]), 32'hA5);

    // T5: load 3C from ch1, then stall three cycles, then drain+fill from ch2.
    in_data   = 32'h44_5A_3C_10;
    in_valid  = 4'b1111;
    sel       = 2'd1;
    out_ready = 1'b0;
    after_edge();
    chk("t5_load_data", 32'(od[0]), 32'h3C);
    chk("t5_load_ch", 32'(oc[0]), 32'd1);
    sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_in_ready", 32'(ir[0]), 32'h0);
      after_edge();
      chk("t5_stall_data", 32'(od[0]), 32'h3C);
      chk("t5_stall_ch", 32'(oc[0]), 32'd1);
      chk("t5_stall_valid", 32'(ov[0]), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_release_in_ready", 32'(ir[0]), 32'h4);
    after_edge();
    chk("t5_fill_data", 32'(od[0]), 32'h5A);
    chk("t5_fill_ch", 32'(oc[0]), 32'd2);
    chk("t5_fill_valid", 32'(ov[0]), 32'd1);

    // T4: round-robin fairness with all channels valid.
    do_reset();
    in_data   = 32'hD3_C2_B1_A0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      after_edge();
      chk("t4_rr_ch", 32'(oc[1]), 32'(i % 4));
      chk("t4_rr_valid", 32'(ov[1]), 32'd1);
    end

    // T1: asynchronous reset in the middle of traffic.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("t1_out_valid", 32'(ov[m]), 32'd0);
      chk("t1_out_data", 32'(od[m]), 32'd0);
      chk("t1_out_ch", 32'(oc[m]), 32'd0);
      chk("t1_in_ready", 32'(ir[m]), 32'd0);
    end
    after_edge();
    reset = 1'b0;

    // T6: sparse round-robin from rr_ptr=3 with only ch1 and ch3 valid.
    in_valid = 4'b1010;
    after_edge();
    chk("t6_first", 32'(oc[1]), 32'd1);
    after_edge();
    chk("t6_second", 32'(oc[1]), 32'd3);
    chk("t6_second_valid", 32'(ov[1]), 32'd1);
    after_edge();
    chk("t6_third", 32'(oc[1]), 32'd1);
    chk("t6_third_data", 32'(od[1]), 32'hB1);

    // Idle tail: nothing valid, registers empty.
    in_valid = 4'b0000;
    after_edge();
    chk("tail_empty", 32'(ov[1]), 32'd0);
    after_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
